min_max_bar_ctrl: RTL and testbench
===================================

# min_max_bar_ctrl

Clocked, parametrised successor of the min/max LED bar display. It owns its own blink oscillator and holds its configuration (mode, min, max) in registers loaded by strobe. Values arrive as a separate stream. Two modes are new: a running-dot sweep and a peak-hold bar. It sits between the user-input front end (switch debouncers) and the LED drivers, and drives `leds_o` from registers.

## Interface
- `VALSIZE`, default 4: value width; `leds_o` is 2**VALSIZE bits wide.
- `BLINK_DIV`, default 4: blink half-period in clock cycles; must be ≥1.
- `clk_i` in 1: single clock; all logic is rising-edge.
- `rst_i` in 1: reset, asynchronous, active-high.
- `cfg_load_i` in 1: when 1, captures `com_i`, `min_i` and `max_i`.
- `com_i` in 3: mode code, type `mode_t`.
- `min_i` in VALSIZE: lower bound of the bar.
- `max_i` in VALSIZE: upper bound of the bar.
- `val_valid_i` in 1: when 1, captures `val_i`.
- `val_i` in VALSIZE: displayed value.
- `err_o` out 1: one-cycle pulse on a rejected configuration.
- `osc_o` out 1: current blink phase.
- `leds_o` out 2**VALSIZE: LED bar; bit i is LED i.

## Operation
- Reset values: mode=OFF, min=0, max=2**VALSIZE-1, val=0, peak=0, sweep pos=0, blink counter=0, `osc_o`=0, `err_o`=0, `leds_o`=0.
- Blink generator:
  - counter runs 0..BLINK_DIV-1 and wraps;
  - at each wrap `osc_o` toggles and a one-cycle `tick` is asserted;
  - free-running in every mode.
- Config load: when `cfg_load_i`=1 and min_i ≤ max_i:
  - mode, min and max are updated;
  - peak is cleared to 0;
  - sweep pos is set to min_i;
  - blink counter and `osc_o` are not affected.
- Config reject: when `cfg_load_i`=1 and min_i > max_i:
  - all config registers keep their previous value;
  - `err_o`=1 for exactly one cycle.
- Value load: when `val_valid_i`=1:
  - val is set to val_i;
  - peak is set to max(peak, val_i), unsigned compare.
- Simultaneous `cfg_load_i` and `val_valid_i`: both are applied at the same edge. The peak clear takes priority, so peak becomes val_i.
- Modes (`mode_t`):
  - NORMAL 3'b000: if min ≤ val ≤ max, LEDs [min..val]=1 and LEDs (val..max]=`osc_o`; all others 0. If val is outside [min, max], all LEDs are 0.
  - LINEAR 3'b001: LEDs [0..val]=1, all others 0.
  - OFF 3'b010: all LEDs 0.
  - ON 3'b011: all LEDs 1.
  - SWEEP 3'b100: exactly one LED is on, at index pos. On each `tick`, pos increments; when pos = max, the next step sets pos to min. With min = max the dot stays fixed.
  - PEAK 3'b101: LEDs [min..val]=1 if val is in range, as in NORMAL without blink. LED peak is also 1 if min ≤ peak ≤ max.
  - 3'b110 and 3'b111: treated as OFF.
- Arithmetic: all comparisons are unsigned at VALSIZE bits. pos+1 never overflows, because pos ≤ max and pos wraps back at max.

## Timing
- Configuration and value registers update at edge k, where the strobe is sampled.
- `leds_o` is registered: at edge k+1 it reflects the registers updated at edge k. Latency from strobe to LEDs is 1 cycle.
- Strobes have no handshake and no backpressure; every cycle is accepted.
- `err_o` is registered and high during the cycle after edge k.
- `osc_o` toggles every BLINK_DIV cycles, so the blink period is 2·BLINK_DIV cycles. `leds_o` reflects a new `osc_o` value one cycle after it changes.
- SWEEP pos advances on the same edge where `osc_o` toggles, and is visible on `leds_o` one cycle later.
- Reset asserted mid-operation: all outputs go to their reset values immediately (asynchronously). Operation resumes at the first rising edge after `rst_i` falls.

## Structure
- Package `min_max_pkg`:
  - `mode_t` enum (3 bits) with the values listed above;
  - parametrised-width helper functions for range checks and for building the bar mask (`bar_mask(lo, hi)`).
- Sub-module `blink_gen`:
  - parameter BLINK_DIV;
  - ports `clk_i`, `rst_i`, `osc_o`, `tick_o`.
- Top-level logic: config/value/peak/pos registers, combinational LED decode, and the output register.

## Test plan
Bench parameters: VALSIZE=4, BLINK_DIV=4.
- After reset, with no strobes → `leds_o`=0 and `osc_o`=0. `osc_o` first rises after 4 cycles and toggles every 4 cycles after that.
- Load NORMAL with min=3, max=12, then val=8 → `leds_o` bits 3..8 are 1 and bits 9..12 follow `osc_o`. With val=13, `leds_o`=0.
- Load min=9, max=4 while in LINEAR with val=5 → `err_o` is high for 1 cycle and `leds_o` stays 16'h003F.
- Load SWEEP with min=2, max=4 → the dot visits positions 2, 3, 4, 2, … with each step on a `tick`.
- Load PEAK with min=0, max=15, then val 7, 11, 5 → final `leds_o` has bits 0..5 and bit 11 set. A new cfg_load clears peak.
- Assert `rst_i` mid-SWEEP → `leds_o` goes to 0 without waiting for a clock edge, and mode returns to OFF.

Source files
------------

// File: rtl/min_max_pkg.sv
// Shared types and helpers for the min/max LED bar controller.
package min_max_pkg;

    // Display mode codes; 3'b110 and 3'b111 are unused and decode as OFF.
    typedef enum logic [2:0] {
        MODE_NORMAL = 3'b000,
        MODE_LINEAR = 3'b001,
        MODE_OFF    = 3'b010,
        MODE_ON     = 3'b011,
        MODE_SWEEP  = 3'b100,
        MODE_PEAK   = 3'b101
    } mode_t;

    // Helpers work on a fixed maximum bar width; callers slice the low
    // 2**VALSIZE bits, so VALSIZE must not exceed MAX_VALSIZE.
    localparam int unsigned MAX_VALSIZE = 32'd8;
    localparam int unsigned MAX_LEDS    = 32'd1 << MAX_VALSIZE;

    // Unsigned check that lo <= v <= hi.
    function automatic logic in_range(input int unsigned v,
                                      input int unsigned lo,
                                      input int unsigned hi);
        return (v >= lo) && (v <= hi);
    endfunction

    // Mask with bits lo..hi set (inclusive); empty when lo > hi.
    function automatic logic [MAX_LEDS-1:0] bar_mask(input int unsigned lo,
                                                     input int unsigned hi);
        logic [MAX_LEDS-1:0] ones;
        ones = {MAX_LEDS{1'b1}};
        if (lo > hi) begin
            return {MAX_LEDS{1'b0}};
        end else begin
            return (ones << lo) & (ones >> (MAX_LEDS - 32'd1 - hi));
        end
    endfunction

endpackage

// File: rtl/min_max_bar_ctrl_blink_gen.sv
// Free-running blink oscillator: osc_o toggles every BLINK_DIV cycles and
// tick_o marks the cycle whose rising edge performs that toggle.
module blink_gen #(
    parameter int BLINK_DIV = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    output logic osc_o,
    output logic tick_o
);

    localparam int CNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             osc_q, osc_d;

    // Counter wrap detection and next oscillator phase.
    always_comb begin
        tick_o = (cnt_q == CNT_LAST);
        if (tick_o) begin
            cnt_d = {CNT_W{1'b0}};
            osc_d = ~osc_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
            osc_d = osc_q;
        end
    end

    // Counter and phase registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= {CNT_W{1'b0}};
            osc_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            osc_q <= osc_d;
        end
    end

    assign osc_o = osc_q;

endmodule

// File: rtl/min_max_bar_ctrl.sv
// Min/max LED bar controller: strobed configuration, value stream, peak
// tracking, running-dot sweep and a registered LED output.
module min_max_bar_ctrl
    import min_max_pkg::*;
#(
    parameter int VALSIZE   = 4,
    parameter int BLINK_DIV = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cfg_load_i,
    input  mode_t                 com_i,
    input  logic [VALSIZE-1:0]    min_i,
    input  logic [VALSIZE-1:0]    max_i,
    input  logic                  val_valid_i,
    input  logic [VALSIZE-1:0]    val_i,
    output logic                  err_o,
    output logic                  osc_o,
    output logic [2**VALSIZE-1:0] leds_o
);

    localparam int NLEDS = 2**VALSIZE;

    mode_t                mode_q, mode_d;
    logic [VALSIZE-1:0]   min_q, min_d;
    logic [VALSIZE-1:0]   max_q, max_d;
    logic [VALSIZE-1:0]   val_q, val_d;
    logic [VALSIZE-1:0]   peak_q, peak_d;
    logic [VALSIZE-1:0]   pos_q, pos_d;
    logic                 err_q, err_d;
    logic [NLEDS-1:0]     leds_q, leds_d;

    logic                 osc_s;
    logic                 tick_s;
    logic                 cfg_ok_s;
    logic                 val_in_s;
    logic                 peak_in_s;
    logic [MAX_LEDS-1:0]  bar_s;
    logic [MAX_LEDS-1:0]  tail_s;
    logic [MAX_LEDS-1:0]  full_s;

    blink_gen #(
        .BLINK_DIV (BLINK_DIV)
    ) u_blink (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .osc_o  (osc_s),
        .tick_o (tick_s)
    );

    // Next state of configuration, value, peak and sweep position.
    always_comb begin
        cfg_ok_s = cfg_load_i && (min_i <= max_i);
        err_d    = cfg_load_i && (min_i > max_i);

        if (cfg_ok_s) begin
            mode_d = com_i;
            min_d  = min_i;
            max_d  = max_i;
        end else begin
            mode_d = mode_q;
            min_d  = min_q;
            max_d  = max_q;
        end

        if (val_valid_i) begin
            val_d = val_i;
        end else begin
            val_d = val_q;
        end

        // A config load clears the peak before a same-cycle value is folded in.
        if (cfg_ok_s) begin
            peak_d = val_valid_i ? val_i : {VALSIZE{1'b0}};
        end else if (val_valid_i) begin
            peak_d = (val_i > peak_q) ? val_i : peak_q;
        end else begin
            peak_d = peak_q;
        end

        // pos never exceeds max, so the increment cannot overflow.
        if (cfg_ok_s) begin
            pos_d = min_i;
        end else if (tick_s && (mode_q == MODE_SWEEP)) begin
            pos_d = (pos_q == max_q) ? min_q : pos_q + VALSIZE'(1);
        end else begin
            pos_d = pos_q;
        end
    end

    // LED pattern decode from the current register state.
    always_comb begin
        val_in_s  = in_range(32'(val_q), 32'(min_q), 32'(max_q));
        peak_in_s = in_range(32'(peak_q), 32'(min_q), 32'(max_q));
        bar_s     = bar_mask(32'(min_q), 32'(val_q));
        tail_s    = bar_mask(32'(val_q) + 32'd1, 32'(max_q));
        full_s    = {MAX_LEDS{1'b0}};
        case (mode_q)
            MODE_NORMAL: begin
                if (val_in_s) begin
                    full_s = bar_s | (osc_s ? tail_s : {MAX_LEDS{1'b0}});
                end else begin
                    full_s = {MAX_LEDS{1'b0}};
                end
            end
            MODE_LINEAR: full_s = bar_mask(32'd0, 32'(val_q));
            MODE_OFF:    full_s = {MAX_LEDS{1'b0}};
            MODE_ON:     full_s = {MAX_LEDS{1'b1}};
            MODE_SWEEP:  full_s = bar_mask(32'(pos_q), 32'(pos_q));
            MODE_PEAK: begin
                full_s = (val_in_s ? bar_s : {MAX_LEDS{1'b0}})
                       | (peak_in_s ? bar_mask(32'(peak_q), 32'(peak_q))
                                    : {MAX_LEDS{1'b0}});
            end
            default:     full_s = {MAX_LEDS{1'b0}};
        endcase
        leds_d = full_s[NLEDS-1:0];
    end

    // State and output registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mode_q <= MODE_OFF;
            min_q  <= {VALSIZE{1'b0}};
            max_q  <= {VALSIZE{1'b1}};
            val_q  <= {VALSIZE{1'b0}};
            peak_q <= {VALSIZE{1'b0}};
            pos_q  <= {VALSIZE{1'b0}};
            err_q  <= 1'b0;
            leds_q <= {NLEDS{1'b0}};
        end else begin
            mode_q <= mode_d;
            min_q  <= min_d;
            max_q  <= max_d;
            val_q  <= val_d;
            peak_q <= peak_d;
            pos_q  <= pos_d;
            err_q  <= err_d;
            leds_q <= leds_d;
        end
    end

    assign err_o  = err_q;
    assign osc_o  = osc_s;
    assign leds_o = leds_q;

endmodule

// File: tb/tb_min_max_bar_ctrl.sv
// Directed testbench for min_max_bar_ctrl (VALSIZE=4, BLINK_DIV=4).
module tb_min_max_bar_ctrl;
    import min_max_pkg::*;

    localparam int VS = 4;
    localparam int BD = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          cfg_load;
    mode_t         com;
    logic [VS-1:0] min_v;
    logic [VS-1:0] max_v;
    logic          val_valid;
    logic [VS-1:0] val;
    logic          err;
    logic          osc;
    logic [15:0]   leds;

    int errs   = 0;
    int checks = 0;
    int cyc    = 0;
    int pos_now;

    min_max_bar_ctrl #(
        .VALSIZE   (VS),
        .BLINK_DIV (BD)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .cfg_load_i  (cfg_load),
        .com_i       (com),
        .min_i       (min_v),
        .max_i       (max_v),
        .val_valid_i (val_valid),
        .val_i       (val),
        .err_o       (err),
        .osc_o       (osc),
        .leds_o      (leds)
    );

    always #5 clk = ~clk;

    // Rising edges since reset release, used to predict the blink phase.
    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic check_val(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // osc_o after c rising edges since reset release.
    function automatic logic osc_model(input int c);
        return ((c / BD) % 2) == 1;
    endfunction

    task automatic step();
        @(negedge clk);
    endtask

    task automatic load_cfg(input mode_t m, input logic [VS-1:0] mn,
                            input logic [VS-1:0] mx);
        cfg_load = 1'b1; com = m; min_v = mn; max_v = mx;
        step();
        cfg_load = 1'b0;
    endtask

    task automatic put_val(input logic [VS-1:0] v);
        val_valid = 1'b1; val = v;
        step();
        val_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; cfg_load = 1'b0; com = MODE_OFF;
        min_v = 4'd0; max_v = 4'd0; val_valid = 1'b0; val = 4'd0;
        repeat (3) step();
        check_val("rst_leds", 32'(leds), 32'h0);
        check_val("rst_osc", 32'(osc), 32'h0);
        check_val("rst_err", 32'(err), 32'h0);
        rst = 1'b0;

        // Free-running blink: first rise after 4 edges, then every 4.
        for (int i = 0; i < 9; i++) begin
            step();
            check_val("osc_phase", 32'(osc), 32'(osc_model(cyc)));
            check_val("off_leds", 32'(leds), 32'h0);
        end

        // NORMAL min=3 max=12 val=8: bits 3..8 solid, 9..12 blink.
        load_cfg(MODE_NORMAL, 4'd3, 4'd12);
        put_val(4'd8);
        for (int i = 0; i < 8; i++) begin
            step();
            check_val("normal_v8", 32'(leds),
                      osc_model(cyc - 1) ? 32'h1FF8 : 32'h01F8);
        end
        put_val(4'd13);
        step();
        check_val("normal_out", 32'(leds), 32'h0);
        put_val(4'd12);
        step();
        check_val("normal_max", 32'(leds), 32'h1FF8);

        // LINEAR val=5, loaded together with the config.
        cfg_load = 1'b1; com = MODE_LINEAR; min_v = 4'd0; max_v = 4'd15;
        val_valid = 1'b1; val = 4'd5;
        step();
        cfg_load = 1'b0; val_valid = 1'b0;
        step();
        check_val("linear_v5", 32'(leds), 32'h003F);

        // Rejected config min=9 > max=4.
        load_cfg(MODE_NORMAL, 4'd9, 4'd4);
        check_val("rej_err_hi", 32'(err), 32'h1);
        check_val("rej_leds0", 32'(leds), 32'h003F);
        step();
        check_val("rej_err_lo", 32'(err), 32'h0);
        check_val("rej_leds1", 32'(leds), 32'h003F);

        // SWEEP 2..4: dot steps on every blink toggle edge.
        load_cfg(MODE_SWEEP, 4'd2, 4'd4);
        pos_now = 2;
        for (int i = 0; i < 20; i++) begin
            step();
            check_val("sweep_dot", 32'(leds), 32'd1 << pos_now);
            if (cyc % BD == 0) pos_now = (pos_now == 4) ? 2 : pos_now + 1;
        end

        // SWEEP with min = max keeps the dot fixed.
        load_cfg(MODE_SWEEP, 4'd7, 4'd7);
        for (int i = 0; i < 8; i++) begin
            step();
            check_val("sweep_fixed", 32'(leds), 32'h0080);
        end

        load_cfg(MODE_ON, 4'd0, 4'd15);
        step();
        check_val("on_leds", 32'(leds), 32'hFFFF);
        load_cfg(mode_t'(3'b110), 4'd0, 4'd15);
        step();
        check_val("rsvd_off", 32'(leds), 32'h0);

        // PEAK: values 7, 11, 5 -> bar 0..5 plus peak dot at 11.
        load_cfg(MODE_PEAK, 4'd0, 4'd15);
        put_val(4'd7);
        put_val(4'd11);
        put_val(4'd5);
        step();
        check_val("peak_hold", 32'(leds), 32'h083F);
        load_cfg(MODE_PEAK, 4'd6, 4'd15);
        step();
        check_val("peak_clear", 32'(leds), 32'h0);
        put_val(4'd12);
        step();
        check_val("peak_v12", 32'(leds), 32'h1FC0);
        cfg_load = 1'b1; com = MODE_PEAK; min_v = 4'd0; max_v = 4'd15;
        val_valid = 1'b1; val = 4'd3;
        step();
        cfg_load = 1'b0; val_valid = 1'b0;
        step();
        check_val("peak_simul", 32'(leds), 32'h000F);

        // Asynchronous reset in the middle of a sweep.
        load_cfg(MODE_SWEEP, 4'd2, 4'd4);
        repeat (3) step();
        check_val("sweep_live", 32'(leds != 16'h0), 32'h1);
        #2;
        rst = 1'b1;
        #1;
        check_val("async_leds", 32'(leds), 32'h0);
        check_val("async_osc", 32'(osc), 32'h0);
        step();
        rst = 1'b0;
        repeat (2) step();
        check_val("post_rst_off", 32'(leds), 32'h0);
        check_val("post_rst_osc", 32'(osc), 32'(osc_model(cyc)));

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
